// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage controller and the
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 multi-cycle multiply/divide unit with architectural HI/LO registers.
// WIDTH iteration cycles followed by one sign-fixup cycle.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } stateT;

    stateT state;
    stateT nextState;

    logic [CW-1:0]      counter;
    logic               isDiv;
    logic               negResult;
    logic               negRem;
    logic               divZero;
    logic [WIDTH-1:0]   aOrig;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               doneReg;
    logic               dbzReg;

    logic               accept;
    logic               opSigned;
    logic               opDiv;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magBIn;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divFits;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quotNext;

    logic [2*WIDTH-1:0] productFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    // op[2]==0 selects the four arithmetic ops; op[0]==0 marks the signed ones.
    assign accept   = (state == IDLE) && bus.start && !bus.op[2];
    assign opSigned = !bus.op[0];
    assign opDiv    = bus.op[1];
    assign aNeg     = opSigned && bus.a[WIDTH-1];
    assign bNeg     = opSigned && bus.b[WIDTH-1];
    assign magA     = aNeg ? -bus.a : bus.a;
    assign magBIn   = bNeg ? -bus.b : bus.b;

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right with the carry.
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magB} : '0);
    assign mulNext = {mulSum, acc[WIDTH-1:1]};

    // Restoring step: the dividend shifts out of acc's low half while quotient
    // bits shift in behind it.
    assign divShift = {rem, acc[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, magB};
    assign divFits  = divShift >= {1'b0, magB};
    assign remNext  = WIDTH'(divFits ? divDiff : divShift);
    assign quotNext = {acc[WIDTH-2:0], divFits};

    assign productFix = negResult ? -acc : acc;
    assign quotFix    = negResult ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remFix     = negRem ? -rem : rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = RUN;
            RUN:     if (counter == LAST_ITER) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter   <= '0;
            isDiv     <= 1'b0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
            aOrig     <= '0;
            magB      <= '0;
            rem       <= '0;
            acc       <= '0;
            hiReg     <= '0;
            loReg     <= '0;
            doneReg   <= 1'b0;
            dbzReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        counter   <= '0;
                        isDiv     <= opDiv;
                        negResult <= aNeg ^ bNeg;
                        negRem    <= aNeg;
                        divZero   <= opDiv && (bus.b == '0);
                        aOrig     <= bus.a;
                        magB      <= magBIn;
                        rem       <= '0;
                        acc       <= {{WIDTH{1'b0}}, magA};
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hiReg <= bus.a;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        loReg <= bus.a;
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (isDiv) begin
                        rem              <= remNext;
                        acc[WIDTH-1:0]   <= quotNext;
                    end else begin
                        acc <= mulNext;
                    end
                end
                FIX: begin
                    doneReg <= 1'b1;
                    dbzReg  <= divZero;
                    if (isDiv && divZero) begin
                        hiReg <= aOrig;
                        loReg <= '1;
                    end else if (isDiv) begin
                        hiReg <= remFix;
                        loReg <= quotFix;
                    end else begin
                        hiReg <= productFix[2*WIDTH-1:WIDTH];
                        loReg <= productFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = doneReg;
    assign bus.div_by_zero = dbzReg;
    assign bus.hi          = hiReg;
    assign bus.lo          = loReg;

endmodule
